// File: rtl/urna_param.sv
// urna_param: electronic ballot box; keyed vote codes are tallied per candidate, blank and null, read back once closed.
module urna_param #(
  parameter int N_CAND = 4,
  parameter int N_DIG  = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             open,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             confirm,
  input  logic             cancel,
  input  logic             finish,
  input  logic [4:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W+3:0] total,
  output logic [1:0]       estado,
  output logic [1:0]       vote_status,
  output logic             vote_done,
  output logic             dig_err
);
  localparam int NT = N_CAND + 2;
  localparam int TW = CNT_W + 4;
  typedef enum logic [1:0] {IDLE = 2'b00, DIG = 2'b01, CONF = 2'b10, CLOSED = 2'b11} state_t;
  state_t state, state_nx;
  logic [9:0] code, code_nx;
  logic [2:0] cnt, cnt_nx;
  logic [CNT_W-1:0] tally [NT];
  logic do_clear, do_cast, bad_dig;
  logic [4:0] cast_idx;
  logic [1:0] cast_status;
  logic [CNT_W-1:0] rd_mux;
  logic [TW-1:0] sum;
  assign estado = state;
  assign cast_idx = code == 10'd0 ? 5'(N_CAND) : code <= 10'(N_CAND) ? 5'(code - 10'd1) : 5'(N_CAND + 1);
  assign cast_status = code == 10'd0 ? 2'b10 : code <= 10'(N_CAND) ? 2'b01 : 2'b11;
  // A confirm that is not honoured falls through so a simultaneous digit still counts.
  always_comb begin
    state_nx = state;
    code_nx  = code;
    cnt_nx   = cnt;
    do_clear = 1'b0;
    do_cast  = 1'b0;
    bad_dig  = 1'b0;
    case (state)
      IDLE, CLOSED: if (open) begin
        state_nx = DIG;
        do_clear = 1'b1;
        code_nx  = '0;
        cnt_nx   = '0;
      end
      default: begin
        if (finish) begin
          state_nx = CLOSED;
          code_nx  = '0;
          cnt_nx   = '0;
        end else if (cancel) begin
          state_nx = DIG;
          code_nx  = '0;
          cnt_nx   = '0;
        end else if (confirm && (state == CONF || cnt == 3'd0)) begin
          state_nx = DIG;
          do_cast  = 1'b1;
          code_nx  = '0;
          cnt_nx   = '0;
        end else if (digit_valid) begin
          if (state == CONF || digit > 4'd9) bad_dig = 1'b1;
          else begin
            code_nx = code * 10'd10 + {6'd0, digit};
            cnt_nx  = cnt + 3'd1;
            state_nx = cnt_nx == 3'(N_DIG) ? CONF : DIG;
          end
        end
      end
    endcase
  end
  always_comb begin
    sum    = '0;
    rd_mux = '0;
    for (int i = 0; i < NT; i++) begin
      sum = sum + TW'(tally[i]);
      if (rd_idx == 5'(i)) rd_mux = tally[i];
    end
  end
  // Readout registers look at the next state so they are already 0 on the first cycle after leaving CLOSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      code        <= '0;
      cnt         <= '0;
      rd_data     <= '0;
      total       <= '0;
      vote_status <= 2'b00;
      vote_done   <= 1'b0;
      dig_err     <= 1'b0;
      for (int i = 0; i < NT; i++) tally[i] <= '0;
    end else begin
      state     <= state_nx;
      code      <= code_nx;
      cnt       <= cnt_nx;
      vote_done <= do_cast;
      dig_err   <= bad_dig;
      if (do_cast) vote_status <= cast_status;
      for (int i = 0; i < NT; i++)
        if (do_clear) tally[i] <= '0;
        else if (do_cast && cast_idx == 5'(i) && tally[i] != '1) tally[i] <= tally[i] + 1'b1;
      rd_data <= state_nx == CLOSED ? rd_mux : '0;
      total   <= state_nx == CLOSED ? sum : '0;
    end
  end
endmodule
